// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: ALU/operand/size enums, RV32I encoding
// constants and the decoded-bundle struct carried through the FIFO.
package decode_queue_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    ALU_SRC_RS1,
    ALU_SRC_RS2,
    ALU_SRC_IMM,
    ALU_SRC_ZERO
  } alu_src_e;

  // Encoded to match the load funct3 field (size in [1:0], unsigned in [2]).
  typedef enum logic [2:0] {
    DATA_B  = 3'b000,
    DATA_H  = 3'b001,
    DATA_W  = 3'b010,
    DATA_BU = 3'b100,
    DATA_HU = 3'b101
  } data_size_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]  sel_rs1;
    logic [4:0]  sel_rs2;
    logic [4:0]  sel_rd;
    logic        rd_we;
    alu_op_e     alu_op;
    alu_src_e    alu_src1;
    alu_src_e    alu_src2;
    logic        mem_re;
    logic        mem_we;
    data_size_e  mem_size;
    logic [31:0] imm;
    logic        illegal;
  } decoded_instr_t;

  localparam int BUNDLE_W = $bits(decoded_instr_t);

  // Illegal encodings decode to an all-zero bundle with only the flag set.
  localparam decoded_instr_t ILLEGAL_BUNDLE =
    decoded_instr_t'({{(BUNDLE_W - 1){1'b0}}, 1'b1});

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle of the decode queue.
// master = fetch/execute environment, slave = the queue itself.
interface decode_queue_if
  import decode_queue_pkg::*;
#(
  parameter int PC_W = 32
);

  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [PC_W-1:0] pc_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [PC_W-1:0] pc_o;
  logic [4:0]      sel_rs1_o;
  logic [4:0]      sel_rs2_o;
  logic [4:0]      sel_rd_o;
  logic            rd_we_o;
  alu_op_e         alu_op_o;
  alu_src_e        alu_src1_o;
  alu_src_e        alu_src2_o;
  logic            mem_re_o;
  logic            mem_we_o;
  data_size_e      mem_size_o;
  logic [31:0]     imm_o;
  logic            illegal_o;

  modport master (
    output in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, sel_rs1_o, sel_rs2_o, sel_rd_o,
           rd_we_o, alu_op_o, alu_src1_o, alu_src2_o, mem_re_o, mem_we_o,
           mem_size_o, imm_o, illegal_o
  );

  modport slave (
    input  in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, sel_rs1_o, sel_rs2_o, sel_rd_o,
           rd_we_o, alu_op_o, alu_src1_o, alu_src2_o, mem_re_o, mem_we_o,
           mem_size_o, imm_o, illegal_o
  );

endinterface

// File: rtl/decode_queue_decode_logic.sv
// Combinational RV32I decoder for ALU, load, store and LUI instructions.
// Anything else, or a malformed funct3/funct7, yields ILLEGAL_BUNDLE.
module decode_logic
  import decode_queue_pkg::*;
(
  input  logic [31:0]    instr,
  output decoded_instr_t dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] imm_sh;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i  = sext12(instr[31:20]);
  assign imm_s  = sext12({instr[31:25], instr[11:7]});
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  alu_op_e        base_op;
  decoded_instr_t d;
  logic           legal;

  // Operation implied by funct3 alone; SUB/SRA are picked by funct7 below.
  always_comb begin
    base_op = ALU_ADD;
    case (funct3)
      F3_ADD_SUB: base_op = ALU_ADD;
      F3_SLL:     base_op = ALU_SLL;
      F3_SLT:     base_op = ALU_SLT;
      F3_SLTU:    base_op = ALU_SLTU;
      F3_XOR:     base_op = ALU_XOR;
      F3_SRL_SRA: base_op = ALU_SRL;
      F3_OR:      base_op = ALU_OR;
      F3_AND:     base_op = ALU_AND;
      default:    base_op = ALU_ADD;
    endcase
  end

  always_comb begin
    // NOTE: every output of a combinational block is assigned a default
    // first, so no path leaves it unassigned and no latch is inferred.
    d     = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        d.sel_rs1  = rs1;
        d.sel_rs2  = rs2;
        d.sel_rd   = rd;
        d.alu_src1 = ALU_SRC_RS1;
        d.alu_src2 = ALU_SRC_RS2;
        d.alu_op   = base_op;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          legal    = 1'b1;
          d.alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
          legal    = 1'b1;
          d.alu_op = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        d.sel_rs1  = rs1;
        d.sel_rd   = rd;
        d.alu_src1 = ALU_SRC_RS1;
        d.alu_src2 = ALU_SRC_IMM;
        d.alu_op   = base_op;
        d.imm      = imm_i;
        if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
          // Shift amount is instr[24:20]; the upper bits must be a valid funct7.
          d.imm = imm_sh;
          if (funct7 == F7_BASE) begin
            legal = 1'b1;
          end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
            legal    = 1'b1;
            d.alu_op = ALU_SRA;
          end
        end else begin
          legal = 1'b1;
        end
      end
      OPC_LOAD: begin
        d.sel_rs1  = rs1;
        d.sel_rd   = rd;
        d.alu_src1 = ALU_SRC_RS1;
        d.alu_src2 = ALU_SRC_IMM;
        d.alu_op   = ALU_ADD;
        d.mem_re   = 1'b1;
        d.imm      = imm_i;
        legal      = 1'b1;
        case (funct3)
          F3_LB:   d.mem_size = DATA_B;
          F3_LH:   d.mem_size = DATA_H;
          F3_LW:   d.mem_size = DATA_W;
          F3_LBU:  d.mem_size = DATA_BU;
          F3_LHU:  d.mem_size = DATA_HU;
          default: legal      = 1'b0;
        endcase
      end
      OPC_STORE: begin
        d.sel_rs1  = rs1;
        d.sel_rs2  = rs2;
        d.alu_src1 = ALU_SRC_RS1;
        d.alu_src2 = ALU_SRC_IMM;
        d.alu_op   = ALU_ADD;
        d.mem_we   = 1'b1;
        d.imm      = imm_s;
        legal      = 1'b1;
        case (funct3)
          F3_SB:   d.mem_size = DATA_B;
          F3_SH:   d.mem_size = DATA_H;
          F3_SW:   d.mem_size = DATA_W;
          default: legal      = 1'b0;
        endcase
      end
      OPC_LUI: begin
        d.sel_rd   = rd;
        d.alu_src1 = ALU_SRC_ZERO;
        d.alu_src2 = ALU_SRC_IMM;
        d.alu_op   = ALU_ADD;
        d.imm      = imm_u;
        legal      = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Stores leave sel_rd at 0, so a non-zero rd alone implies a write.
    if (!legal) begin
      d = ILLEGAL_BUNDLE;
    end else begin
      d.rd_we = (d.sel_rd != 5'd0);
    end
  end

  assign dec = d;

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry FIFO of decoded bundles between fetch and
// execute. Optional macro DECODE_BYPASS_EN adds a 0-cycle path when empty.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_queue_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  decoded_instr_t  dec;
  decoded_instr_t  mem_q    [DEPTH];
  logic [PC_W-1:0] pc_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  decoded_instr_t   head_q, head_d;
  logic [PC_W-1:0]  head_pc_q, head_pc_d;

  logic            in_ready;
  logic            queued_valid;
  logic            push;
  logic            pop;
  logic            bypass;
  decoded_instr_t  out_bundle;
  logic [PC_W-1:0] out_pc;

  decode_logic u_decode (
    .instr (bus.instr_i),
    .dec   (dec)
  );

  // Wraps at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready     = (count_q < FULL_CNT);
  assign queued_valid = (count_q != '0);

`ifdef DECODE_BYPASS_EN
  assign bypass     = !queued_valid && bus.in_valid_i && bus.out_ready_i && !bus.flush_i;
  assign out_bundle = bypass ? dec : head_q;
  assign out_pc     = bypass ? bus.pc_i : head_pc_q;
`else
  assign bypass     = 1'b0;
  assign out_bundle = head_q;
  assign out_pc     = head_pc_q;
`endif

  assign push = bus.in_valid_i && in_ready && !bus.flush_i && !bypass;
  assign pop  = queued_valid && bus.out_ready_i && !bus.flush_i;

  // head_q mirrors mem_q[rd_ptr_q] but only reloads when the head changes,
  // so the outputs hold their last value while the queue is empty.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    head_pc_d = head_pc_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (bypass) begin
        head_d    = dec;
        head_pc_d = bus.pc_i;
      end else if (push && (count_q == '0 || (pop && count_q == ONE_CNT))) begin
        // The incoming instruction becomes the head directly.
        head_d    = dec;
        head_pc_d = bus.pc_i;
      end else if (pop && count_q > ONE_CNT) begin
        head_d    = mem_q[rd_ptr_d];
        head_pc_d = pc_mem_q[rd_ptr_d];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      head_pc_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      head_pc_q <= head_pc_d;
    end
  end

  // NOTE: the storage array has no reset; only head_q and count_q are ever
  // visible, and both are cleared, so stale slots can never be emitted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]    <= dec;
      pc_mem_q[wr_ptr_q] <= bus.pc_i;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = queued_valid || bypass;
  assign bus.pc_o        = out_pc;
  assign bus.sel_rs1_o   = out_bundle.sel_rs1;
  assign bus.sel_rs2_o   = out_bundle.sel_rs2;
  assign bus.sel_rd_o    = out_bundle.sel_rd;
  assign bus.rd_we_o     = out_bundle.rd_we;
  assign bus.alu_op_o    = out_bundle.alu_op;
  assign bus.alu_src1_o  = out_bundle.alu_src1;
  assign bus.alu_src2_o  = out_bundle.alu_src2;
  assign bus.mem_re_o    = out_bundle.mem_re;
  assign bus.mem_we_o    = out_bundle.mem_we;
  assign bus.mem_size_o  = out_bundle.mem_size;
  assign bus.imm_o       = out_bundle.imm;
  assign bus.illegal_o   = out_bundle.illegal;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-register ID stage.
- Decodes RV32I ALU, load, store and LUI instructions into a control bundle, then buffers decoded bundles in a DEPTH-entry FIFO.
- Valid/ready handshakes on both sides decouple fetch from execute. Adds flush, illegal-instruction flagging, rd write-enable and sign-correct immediates.

Parameters:
DEPTH, 2, number of decoded-bundle entries; legal values 1..8.
PC_W, 32, width of the program counter carried with each bundle.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid_i  in  1  fetch presents instruction
in_ready_o  out  1  queue can accept (count < DEPTH)
instr_i  in  32  raw instruction
pc_i  in  PC_W  instruction address
flush_i  in  1  discard all queued and incoming entries
out_valid_o  out  1  head entry valid
out_ready_i  in  1  execute consumes head
pc_o  out  PC_W  head pc
sel_rs1_o  out  5  rs1 index
sel_rs2_o  out  5  rs2 index
sel_rd_o  out  5  rd index
rd_we_o  out  1  writes register file (rd != 0, not a store)
alu_op_o  out  alu_op_e  ALU operation
alu_src1_o  out  alu_src_e  operand-1 source
alu_src2_o  out  alu_src_e  operand-2 source
mem_re_o  out  1  load
mem_we_o  out  1  store
mem_size_o  out  data_size_e  access size and sign
imm_o  out  32  sign-extended immediate
illegal_o  out  1  unsupported or malformed encoding

Behaviour:
- Reset (rst_n low, asynchronous):
  - count, read pointer and write pointer go to 0.
  - out_valid_o=0, and every bundle output is 0.
- Push when in_valid_i && in_ready_o && !flush_i. Pop when out_valid_o && out_ready_i && !flush_i.
- Latency: an instruction pushed in cycle N is visible at the head in cycle N+1 when the queue was empty.
- Ordering is strict FIFO.
- Outputs are driven from registered storage only, with no combinational path from instr_i to the outputs.
- Full: in_ready_o=0, with no combinational dependence on out_ready_i. Simultaneous push and pop when not full leaves count unchanged.
- Empty: out_valid_o=0, and the bundle outputs hold their last value.
- Pointers wrap modulo DEPTH, and DEPTH need not be a power of two.
- flush_i:
  - Takes priority over push and pop.
  - Next cycle: count=0 and out_valid_o=0.
  - An input presented in the flush cycle is dropped.
  - in_ready_o is 1 in the cycle after the flush.
- Decode rules:
  - R-type ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND: src RS1/RS2, imm=0.
  - I-type ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI: src RS1/IMM, imm=sext(instr[31:20]). For shifts, imm=instr[24:20] zero-extended.
  - Loads LB/LH/LW/LBU/LHU: ALU_ADD, mem_re=1, imm=sext(instr[31:20]).
  - Stores SB/SH/SW: ALU_ADD, mem_we=1, rd_we=0, sel_rd=0, imm=sext({instr[31:25],instr[11:7]}).
  - LUI: imm={instr[31:12],12'b0}, src1 ZERO, ALU_ADD, rs1=0.
- Unused register selects are 0. rd_we=0 whenever rd=0.
- Illegal (unknown opcode/funct3/funct7, or SLLI/SRLI/SRAI with bad funct7):
  - The bundle is all zero except pc and illegal_o=1.
  - It is still queued, so execute can trap in order.
- Reset mid-operation: all entries are lost and no partial bundle is emitted.

Optional Feature:
- Macro DECODE_BYPASS_EN.
- Defined:
  - When the queue is empty, out_ready_i=1, in_valid_i=1 and there is no flush, the decoded bundle is driven combinationally to the outputs with out_valid_o=1.
  - That entry is not stored, giving 0-cycle latency. The count is unchanged.
- Undefined: 1-cycle minimum latency with fully registered outputs.

Decomposition:
- Shared package (existing pkg):
  - decoded_instr_t packed struct holding all bundle fields.
  - New enum values ALU_SRC_ZERO and illegal-encoding constants.
  - Opcode/funct3/funct7 localparams.
  - Reuses alu_op_e, alu_src_e and data_size_e.
- Sub-module decode_logic: purely combinational, takes instr_i and produces decoded_instr_t. The top holds the FIFO storage, pointers, count and handshake logic.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), pushed to the empty queue with out_ready=1 -> next cycle:
  - out_valid=1, rs1=1, rs2=2, rd=3, rd_we=1, alu_op=ALU_ADD, src2=RS2, illegal=0.
- LW x5,-4(x2) (0xFFC12283) -> imm=0xFFFFFFFC, mem_re=1, mem_size=WORD, rd=5. SW x6,8(x1) (0x0060A423) -> imm=0x8, mem_we=1, rd_we=0, rs2=6.
- With out_ready=0, push DEPTH=2 instructions -> in_ready=0 after the second push. Raise out_ready -> entries pop in order, and in_ready returns the cycle after the first pop.
- Fill the queue, then assert flush_i together with in_valid -> next cycle out_valid=0, count 0, the flushed input is never seen.
- 0xFFFFFFFF pushed -> illegal_o=1, rd_we=0, mem_re=mem_we=0, pc preserved.
- Assert rst_n low while 2 entries are queued -> out_valid=0 and all outputs 0 immediately. After release, the first new push emerges correctly.
